delay_pipe_ctrl: RTL

Flow controller for an N-stage, single-enable delay pipeline (the team's `delay_n`-style shift register). It tracks a valid bit per stage and exposes valid/ready handshakes on the pipeline's input and output. It drives the pipeline's shared shift enable, so an output stall freezes every stage without losing data. It also provides drain and flush control plus occupancy and stall statistics for the surrounding datapath.

---
 rtl/delay_pipe_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/delay_pipe_ctrl.sv
// Flow controller for an N-stage single-enable delay pipeline: per-stage valid
// tracking, in/out handshakes, drain/flush control, occupancy and stall stats.
module delay_pipe_ctrl #(
  parameter int N     = 4,
  parameter int CNT_W = 16,
  parameter int OCC_W = $clog2(N + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_pipe_en,
  input  logic             i_drain,
  output logic             o_drain_done,
  input  logic             i_flush,
  output logic [OCC_W-1:0] o_occupancy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     vld, vld_nxt;
  logic [OCC_W-1:0] occ, occ_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             advance, accept, transfer, stall_inc;

  // The whole pipe moves as one; a stalled last stage freezes every stage.
  always_comb begin
    advance      = !vld[N-1] || i_out_ready;
    o_pipe_en    = advance && !i_flush && !i_rst;
    o_in_ready   = advance && (state == RUN) && !i_drain && !i_flush && !i_rst;
    o_out_valid  = vld[N-1] && !i_flush && !i_rst;
    o_drain_done = (state == DONE) && !i_rst;
    accept       = i_in_valid && o_in_ready;
    transfer     = o_out_valid && i_out_ready;
    stall_inc    = vld[N-1] && !i_out_ready && !i_flush && (stall_cnt != '1);
  end

  always_comb begin
    vld_nxt    = vld;
    vld_nxt[0] = accept;
    for (int unsigned k = 1; k < N; k++) begin
      vld_nxt[k] = vld[k-1];
    end
  end

  always_comb begin
    occ_nxt = occ;
    case ({accept, transfer})
      2'b10:   occ_nxt = occ + OCC_W'(1);
      2'b01:   occ_nxt = occ - OCC_W'(1);
      default: occ_nxt = occ;
    endcase
  end

  // Flush leaves the FSM where it is; an emptied DRAIN reaches DONE a cycle later.
  always_comb begin
    state_nxt = state;
    if (!i_flush) begin
      case (state)
        RUN:     if (i_drain) state_nxt = DRAIN;
        DRAIN:   if (!i_drain) state_nxt = RUN;
                 else if (occ == '0) state_nxt = DONE;
        DONE:    if (!i_drain) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= RUN;
      vld       <= '0;
      occ       <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (i_flush) begin
        vld <= '0;
        occ <= '0;
      end else begin
        if (o_pipe_en) vld <= vld_nxt;
        occ <= occ_nxt;
      end
      if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign o_occupancy = occ;
  assign o_stall_cnt = stall_cnt;

endmodule
